// File: rtl/multi_pattern_matcher_if.sv
// rtl/multi_pattern_matcher_if.sv - config, byte-stream and match-report bundle for multi_pattern_matcher
interface multi_pattern_matcher_if #(
    parameter int N_PAT   = 4,
    parameter int MAX_LEN = 8,
    parameter int OFS_W   = 16
);
    localparam int PAT_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
    localparam int POS_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [POS_W-1:0] cfg_pos;
    logic [7:0]       cfg_byte;
    logic             cfg_len_we;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic [7:0]       in_ch;
    logic             in_last;
    logic             match_valid;
    logic [N_PAT-1:0] match_vec;
    logic [PAT_W-1:0] match_id;
    logic [OFS_W-1:0] match_pos;

    modport master (
        output cfg_we, cfg_pat, cfg_pos, cfg_byte, cfg_len_we, cfg_len,
        output in_valid, in_ch, in_last,
        input  match_valid, match_vec, match_id, match_pos
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_pos, cfg_byte, cfg_len_we, cfg_len,
        input  in_valid, in_ch, in_last,
        output match_valid, match_vec, match_id, match_pos
    );
endinterface

// File: rtl/multi_pattern_matcher.sv
// rtl/multi_pattern_matcher.sv - bit-parallel multi-signature byte matcher; define NOCASE_EN for ASCII case-insensitive compare
module multi_pattern_matcher #(
    parameter int N_PAT   = 4,
    parameter int MAX_LEN = 8,
    parameter int OFS_W   = 16
) (
    input logic                   clk,
    input logic                   reset,
    multi_pattern_matcher_if.slave bus
);
    localparam int PAT_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]         pat_mem [N_PAT][MAX_LEN];
    logic [LEN_W-1:0]   len_q   [N_PAT];
    logic [MAX_LEN-1:0] d_q     [N_PAT];
    logic [MAX_LEN-1:0] d_next  [N_PAT];
    logic [N_PAT-1:0]   hit;
    logic [N_PAT-1:0]   cfg_touch;
    logic [PAT_W-1:0]   hit_id;
    logic [LEN_W-1:0]   len_clamped;
    logic [OFS_W-1:0]   ofs_q;
    logic               byte_wr_ok;
    logic               len_wr_ok;

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef NOCASE_EN
        if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
`endif
        return c;
    endfunction

    always_comb begin
        byte_wr_ok  = bus.cfg_we && (int'(bus.cfg_pat) < N_PAT) && (int'(bus.cfg_pos) < MAX_LEN);
        len_wr_ok   = bus.cfg_len_we && (int'(bus.cfg_pat) < N_PAT);
        len_clamped = (int'(bus.cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cfg_len;
        for (int p = 0; p < N_PAT; p++) begin
            cfg_touch[p] = (byte_wr_ok || len_wr_ok) && (int'(bus.cfg_pat) == p);
        end
    end

    // Next-state match vectors and per-signature completion on the current byte.
    // A signature being reconfigured this edge neither advances nor reports.
    always_comb begin
        hit    = '0;
        hit_id = '0;
        for (int p = 0; p < N_PAT; p++) begin
            d_next[p]    = '0;
            d_next[p][0] = fold(bus.in_ch) == fold(pat_mem[p][0]);
            for (int i = 1; i < MAX_LEN; i++) begin
                d_next[p][i] = d_q[p][i-1] && (fold(bus.in_ch) == fold(pat_mem[p][i]));
            end
            for (int i = 0; i < MAX_LEN; i++) begin
                if (int'(len_q[p]) == i + 1) hit[p] = d_next[p][i];
            end
            if (cfg_touch[p]) hit[p] = 1'b0;
        end
        for (int p = N_PAT - 1; p >= 0; p--) begin
            if (hit[p]) hit_id = PAT_W'(p);
        end
    end

    // Signature bytes survive reset; only lengths gate whether they are live.
    always_ff @(posedge clk) begin
        if (byte_wr_ok) pat_mem[bus.cfg_pat][bus.cfg_pos] <= bus.cfg_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < N_PAT; p++) begin
                d_q[p]   <= '0;
                len_q[p] <= '0;
            end
            ofs_q           <= '0;
            bus.match_valid <= 1'b0;
            bus.match_vec   <= '0;
            bus.match_id    <= '0;
            bus.match_pos   <= '0;
        end else begin
            if (len_wr_ok) len_q[bus.cfg_pat] <= len_clamped;

            if (bus.in_valid) begin
                for (int p = 0; p < N_PAT; p++) begin
                    d_q[p] <= bus.in_last ? '0 : d_next[p];
                end
                ofs_q           <= bus.in_last ? '0 : ofs_q + 1'b1;
                bus.match_valid <= |hit;
                bus.match_vec   <= hit;
                bus.match_id    <= (|hit) ? hit_id : '0;
                bus.match_pos   <= (|hit) ? ofs_q : '0;
            end else begin
                bus.match_valid <= 1'b0;
                bus.match_vec   <= '0;
                bus.match_id    <= '0;
                bus.match_pos   <= '0;
            end

            for (int p = 0; p < N_PAT; p++) begin
                if (cfg_touch[p]) d_q[p] <= '0;
            end
        end
    end
endmodule
